// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI configuration responder: opcodes, register map,
// reset values and the frame-decoder state encoding.
package spi_reg_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COEF_W  = 16;
  localparam int unsigned SDM_W   = 15;
  localparam int unsigned BITCNT_W = 3;

  localparam logic [BYTE_W-1:0] CMD_RD       = 8'hC1;
  localparam logic [BYTE_W-1:0] CMD_RD_BURST = 8'hC5;
  localparam logic [BYTE_W-1:0] CMD_WR       = 8'hC2;
  localparam logic [BYTE_W-1:0] CMD_WR_BURST = 8'hCA;

  localparam logic [BYTE_W-1:0] ADDR_SCRATCH = 8'd0;
  localparam logic [BYTE_W-1:0] ADDR_CTRL    = 8'd1;
  localparam logic [BYTE_W-1:0] ADDR_A2_LO   = 8'd2;
  localparam logic [BYTE_W-1:0] ADDR_A2_HI   = 8'd3;
  localparam logic [BYTE_W-1:0] ADDR_A3_LO   = 8'd4;
  localparam logic [BYTE_W-1:0] ADDR_A3_HI   = 8'd5;
  localparam logic [BYTE_W-1:0] ADDR_B1_LO   = 8'd6;
  localparam logic [BYTE_W-1:0] ADDR_B1_HI   = 8'd7;
  localparam logic [BYTE_W-1:0] ADDR_B2_LO   = 8'd8;
  localparam logic [BYTE_W-1:0] ADDR_B2_HI   = 8'd9;
  localparam logic [BYTE_W-1:0] ADDR_SDM_LO  = 8'd10;
  localparam logic [BYTE_W-1:0] ADDR_SDM_HI  = 8'd11;
  localparam logic [BYTE_W-1:0] ADDR_SNAP_LO = 8'd12;
  localparam logic [BYTE_W-1:0] ADDR_SNAP_HI = 8'd13;

  localparam logic [COEF_W-1:0] A2_RST = 16'h7CBE;  //  31934
  localparam logic [COEF_W-1:0] A3_RST = 16'hC340;  // -15552
  localparam logic [COEF_W-1:0] B1_RST = 16'h063A;  //   1594
  localparam logic [COEF_W-1:0] B2_RST = 16'hF9CD;  //  -1587

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

  function automatic logic cmd_valid(input logic [BYTE_W-1:0] cmd);
    return (cmd == CMD_RD) || (cmd == CMD_RD_BURST) ||
           (cmd == CMD_WR) || (cmd == CMD_WR_BURST);
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between the host initiator and the register responder.
interface spi_reg_slave_if;
  logic csn;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output csn, output sclk, output mosi, input miso);
  modport slave  (input csn, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic sys_clk,
  input  logic por_rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Edges appear STAGES+1 cycles after the pin toggles.
  always_ff @(posedge sys_clk or negedge por_rstn) begin
    if (!por_rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= STAGES'({sync_q, din});
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder with the digital loop filter configuration register bank
// and a coherent dlf_out snapshot.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int unsigned REGCOUNT    = 14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     sys_clk,
  input  logic                     por_rstn,
  spi_reg_slave_if.slave           spi,
  input  logic [COEF_W-1:0]        dlf_out,
  output logic signed [COEF_W-1:0] dlf_a2,
  output logic signed [COEF_W-1:0] dlf_a3,
  output logic signed [COEF_W-1:0] dlf_b1,
  output logic signed [COEF_W-1:0] dlf_b2,
  output logic                     dlf_en,
  output logic                     enable_digclk,
  output logic                     digrf_rstn,
  output logic [SDM_W-1:0]         dlf_sdm_nc_in
);

  logic sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .sys_clk (sys_clk),
    .por_rstn(por_rstn),
    .din     (spi.sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn_sync (
    .sys_clk (sys_clk),
    .por_rstn(por_rstn),
    .din     (spi.csn),
    .rise    (csn_rise),
    .fall    (csn_fall)
  );

  always_ff @(posedge sys_clk or negedge por_rstn) begin
    if (!por_rstn) mosi_q <= '0;
    else           mosi_q <= SYNC_STAGES'({mosi_q, spi.mosi});
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  spi_state_e          state;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [BYTE_W-2:0]   shift_q;
  logic [BYTE_W-1:0]   cmd_q;
  logic [BYTE_W-1:0]   addr_q;
  logic [BYTE_W-1:0]   tx_q;
  logic                miso_q;
  logic [BYTE_W-1:0]   scratch_q;
  logic [BYTE_W-1:0]   stage_q;
  // Low snapshot byte is returned in the cycle it is captured; only the high half is held.
  logic [BYTE_W-1:0]   shadow_hi_q;

  logic [BYTE_W-1:0] byte_c, next_addr_c, rd_addr_c, rd_data_c;
  logic byte_done_c, is_read_c, is_burst_c, load_c, wr_c;

  assign byte_c      = {shift_q, mosi_s};
  assign byte_done_c = sclk_rise && !csn_rise && (bit_cnt == BITCNT_W'(7)) &&
                       (state inside {ST_CMD, ST_ADDR, ST_DATA});
  assign is_read_c   = (cmd_q == CMD_RD) || (cmd_q == CMD_RD_BURST);
  assign is_burst_c  = (cmd_q == CMD_RD_BURST) || (cmd_q == CMD_WR_BURST);
  assign next_addr_c = (32'(addr_q) == REGCOUNT - 1) ? '0 : addr_q + 8'd1;
  assign rd_addr_c   = (state == ST_ADDR) ? byte_c : next_addr_c;
  assign load_c      = byte_done_c && is_read_c &&
                       ((state == ST_ADDR) || ((state == ST_DATA) && is_burst_c));
  assign wr_c        = byte_done_c && !is_read_c && (state == ST_DATA);

  always_comb begin
    rd_data_c = '0;
    if (32'(rd_addr_c) < REGCOUNT) begin
      case (rd_addr_c)
        ADDR_SCRATCH: rd_data_c = scratch_q;
        ADDR_CTRL:    rd_data_c = {5'b0, digrf_rstn, enable_digclk, dlf_en};
        ADDR_A2_LO:   rd_data_c = dlf_a2[7:0];
        ADDR_A2_HI:   rd_data_c = dlf_a2[15:8];
        ADDR_A3_LO:   rd_data_c = dlf_a3[7:0];
        ADDR_A3_HI:   rd_data_c = dlf_a3[15:8];
        ADDR_B1_LO:   rd_data_c = dlf_b1[7:0];
        ADDR_B1_HI:   rd_data_c = dlf_b1[15:8];
        ADDR_B2_LO:   rd_data_c = dlf_b2[7:0];
        ADDR_B2_HI:   rd_data_c = dlf_b2[15:8];
        ADDR_SDM_LO:  rd_data_c = dlf_sdm_nc_in[7:0];
        ADDR_SDM_HI:  rd_data_c = {1'b0, dlf_sdm_nc_in[14:8]};
        ADDR_SNAP_LO: rd_data_c = dlf_out[7:0];
        ADDR_SNAP_HI: rd_data_c = shadow_hi_q;
        default:      rd_data_c = '0;
      endcase
    end
  end

  // Frame decoder: csn rise wins over any coincident sclk edge.
  always_ff @(posedge sys_clk or negedge por_rstn) begin
    if (!por_rstn) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
    end else if (csn_rise) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else if (csn_fall) begin
      state   <= ST_CMD;
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (sclk_rise && (state inside {ST_CMD, ST_ADDR, ST_DATA})) begin
        shift_q <= byte_c[BYTE_W-2:0];
        bit_cnt <= bit_cnt + BITCNT_W'(1);
        if (byte_done_c) begin
          case (state)
            ST_CMD: begin
              cmd_q <= byte_c;
              state <= cmd_valid(byte_c) ? ST_ADDR : ST_IGNORE;
            end
            ST_ADDR: begin
              addr_q <= byte_c;
              state  <= ST_DATA;
            end
            ST_DATA: begin
              addr_q <= next_addr_c;
              if (!is_burst_c) state <= ST_IGNORE;
            end
            default: ;
          endcase
        end
      end
      if (load_c) tx_q <= rd_data_c;
      if (sclk_fall) begin
        if ((state == ST_DATA) && is_read_c) begin
          miso_q <= tx_q[BYTE_W-1];
          tx_q   <= {tx_q[BYTE_W-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  assign spi.miso = miso_q;

  // Register bank: 16-bit pairs commit on the high-byte write from the staged low byte.
  always_ff @(posedge sys_clk or negedge por_rstn) begin
    if (!por_rstn) begin
      scratch_q     <= '0;
      stage_q       <= '0;
      shadow_hi_q   <= '0;
      dlf_en        <= 1'b0;
      enable_digclk <= 1'b0;
      digrf_rstn    <= 1'b0;
      dlf_a2        <= A2_RST;
      dlf_a3        <= A3_RST;
      dlf_b1        <= B1_RST;
      dlf_b2        <= B2_RST;
      dlf_sdm_nc_in <= '0;
    end else begin
      if (load_c && (rd_addr_c == ADDR_SNAP_LO)) shadow_hi_q <= dlf_out[15:8];
      if (wr_c && (32'(addr_q) < REGCOUNT)) begin
        case (addr_q)
          ADDR_SCRATCH: scratch_q <= byte_c;
          ADDR_CTRL: begin
            dlf_en        <= byte_c[0];
            enable_digclk <= byte_c[1];
            digrf_rstn    <= byte_c[2];
          end
          ADDR_A2_LO, ADDR_A3_LO, ADDR_B1_LO, ADDR_B2_LO, ADDR_SDM_LO: stage_q <= byte_c;
          ADDR_A2_HI:  dlf_a2 <= {byte_c, stage_q};
          ADDR_A3_HI:  dlf_a3 <= {byte_c, stage_q};
          ADDR_B1_HI:  dlf_b1 <= {byte_c, stage_q};
          ADDR_B2_HI:  dlf_b2 <= {byte_c, stage_q};
          ADDR_SDM_HI: dlf_sdm_nc_in <= {byte_c[6:0], stage_q};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: directed frames plus random frames against a byte-map model.
module tb_spi_reg_slave;
  import spi_reg_pkg::*;

  localparam int unsigned REGCOUNT    = 14;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HALF        = 6;

  logic sys_clk  = 1'b0;
  logic por_rstn = 1'b0;
  logic [15:0] dlf_out;
  logic signed [15:0] dlf_a2, dlf_a3, dlf_b1, dlf_b2;
  logic dlf_en, enable_digclk, digrf_rstn;
  logic [14:0] dlf_sdm_nc_in;

  spi_reg_slave_if spi ();

  spi_reg_slave #(.REGCOUNT(REGCOUNT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .sys_clk      (sys_clk),
    .por_rstn     (por_rstn),
    .spi          (spi),
    .dlf_out      (dlf_out),
    .dlf_a2       (dlf_a2),
    .dlf_a3       (dlf_a3),
    .dlf_b1       (dlf_b1),
    .dlf_b2       (dlf_b2),
    .dlf_en       (dlf_en),
    .enable_digclk(enable_digclk),
    .digrf_rstn   (digrf_rstn),
    .dlf_sdm_nc_in(dlf_sdm_nc_in)
  );

  always #1 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count every value change of dlf_a2 so a torn 16-bit update would be visible.
  logic [15:0] a2_prev = 16'h7CBE;
  int a2_changes = 0;
  always @(negedge sys_clk) begin
    if (dlf_a2 !== a2_prev) a2_changes <= a2_changes + 1;
    a2_prev <= dlf_a2;
  end

  // Model: committed byte image of the map, one staging byte, 16-bit snapshot.
  logic [7:0]  mreg [0:13];
  logic [7:0]  mstage;
  logic [15:0] mshadow;

  task automatic model_reset();
    for (int i = 0; i < 14; i++) mreg[i] = 8'h00;
    mreg[2] = 8'hBE; mreg[3] = 8'h7C;
    mreg[4] = 8'h40; mreg[5] = 8'hC3;
    mreg[6] = 8'h3A; mreg[7] = 8'h06;
    mreg[8] = 8'hCD; mreg[9] = 8'hF9;
    mstage  = 8'h00;
    mshadow = 16'h0000;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a >= int'(REGCOUNT)) return;
    if (a == 0) mreg[0] = d;
    else if (a == 1) mreg[1] = d & 8'h07;
    else if (a >= 2 && a <= 11 && (a % 2) == 0) mstage = d;
    else if (a >= 3 && a <= 11) begin
      mreg[a-1] = mstage;
      mreg[a]   = (a == 11) ? (d & 8'h7F) : d;
    end
  endtask

  task automatic model_read(input int a, output logic [7:0] d);
    if (a >= int'(REGCOUNT)) d = 8'h00;
    else if (a == 12) begin
      mshadow = dlf_out;
      d = mshadow[7:0];
    end else if (a == 13) d = mshadow[15:8];
    else d = mreg[a];
  endtask

  function automatic int model_next(input int a);
    return (a == int'(REGCOUNT) - 1) ? 0 : ((a + 1) & 255);
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_a2"},   {16'b0, dlf_a2}, {16'b0, mreg[3], mreg[2]});
    chk({tag, "_a3"},   {16'b0, dlf_a3}, {16'b0, mreg[5], mreg[4]});
    chk({tag, "_b1"},   {16'b0, dlf_b1}, {16'b0, mreg[7], mreg[6]});
    chk({tag, "_b2"},   {16'b0, dlf_b2}, {16'b0, mreg[9], mreg[8]});
    chk({tag, "_ctrl"}, {29'b0, digrf_rstn, enable_digclk, dlf_en}, {29'b0, mreg[1][2:0]});
    chk({tag, "_sdm"},  {17'b0, dlf_sdm_nc_in}, {17'b0, mreg[11][6:0], mreg[10]});
    chk({tag, "_miso"}, {31'b0, spi.miso}, 32'd0);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic spi_begin();
    spi.csn = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      spi.mosi = b[7-i];
      wait_clk(HALF);
      rx[7-i] = spi.miso;
      spi.sclk = 1'b1;
      wait_clk(HALF);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    spi.csn = 1'b1;
    wait_clk(4 * HALF);
  endtask

  logic [7:0]  rx_q [$];
  logic [15:0] a2_after [$];

  // vary: 0 keep dlf_out, 1 randomize after each byte, 2 zero it after the first data byte.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input int ndata,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int cut_bits, input int vary);
    logic [7:0] fb [5];
    logic [7:0] rx, exp_tx;
    int mode, cur, bits_left, nb;
    fb[0] = cmd; fb[1] = addr; fb[2] = d0; fb[3] = d1; fb[4] = d2;
    rx_q.delete();
    a2_after.delete();
    exp_tx = 8'h00;
    mode = 0;
    cur = 0;
    bits_left = (cut_bits < 0) ? 1000 : cut_bits;
    spi_begin();
    for (int idx = 0; idx < 2 + ndata; idx++) begin
      nb = (bits_left < 8) ? bits_left : 8;
      if (nb == 0) break;
      spi_bits(fb[idx], nb, rx);
      bits_left -= nb;
      if (nb < 8) break;
      rx_q.push_back(rx);
      chk($sformatf("miso_c%02h_a%0d_b%0d", cmd, addr, idx), {24'b0, rx}, {24'b0, exp_tx});
      if (idx == 0) begin
        case (cmd)
          CMD_RD:       mode = 1;
          CMD_RD_BURST: mode = 2;
          CMD_WR:       mode = 3;
          CMD_WR_BURST: mode = 4;
          default:      mode = 0;
        endcase
        exp_tx = 8'h00;
      end else if (idx == 1) begin
        cur = int'(addr);
        if (mode == 1 || mode == 2) model_read(cur, exp_tx);
        else exp_tx = 8'h00;
      end else begin
        case (mode)
          2: begin cur = model_next(cur); model_read(cur, exp_tx); end
          3: begin if (idx == 2) model_write(cur, fb[idx]); exp_tx = 8'h00; end
          4: begin model_write(cur, fb[idx]); cur = model_next(cur); exp_tx = 8'h00; end
          default: exp_tx = 8'h00;
        endcase
        a2_after.push_back(dlf_a2);
      end
      if (vary == 1) dlf_out = 16'($urandom);
      else if (vary == 2 && idx == 2) dlf_out = 16'h0000;
    end
    spi_end();
    check_outputs($sformatf("post_c%02h", cmd));
  endtask

  initial begin
    logic [7:0] rx;
    int ch0, nd, cut;
    logic [7:0] cmd, addr;
    spi.csn  = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    dlf_out  = 16'h0000;
    model_reset();
    wait_clk(5);
    por_rstn = 1'b1;
    wait_clk(10);

    check_outputs("reset");
    chk("rst_a2", {16'b0, dlf_a2}, 32'd31934);
    chk("rst_a3", {16'b0, dlf_a3}, 32'h0000C340);
    chk("rst_b1", {16'b0, dlf_b1}, 32'd1594);
    chk("rst_b2", {16'b0, dlf_b2}, 32'h0000F9CD);

    run_frame(CMD_RD, 8'd3, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("rd_a2_hi", {24'b0, rx_q[2]}, 32'h7C);

    run_frame(CMD_WR, 8'd0, 1, 8'h5A, 8'h00, 8'h00, -1, 0);
    run_frame(CMD_RD, 8'd0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("rd_scratch", {24'b0, rx_q[2]}, 32'h5A);

    run_frame(CMD_WR, 8'd1, 1, 8'h07, 8'h00, 8'h00, -1, 0);
    chk("ctrl_bits", {29'b0, digrf_rstn, enable_digclk, dlf_en}, 32'd7);

    ch0 = a2_changes;
    run_frame(CMD_WR_BURST, 8'd2, 2, 8'h34, 8'h12, 8'h00, -1, 0);
    chk("a2_after_lo", {16'b0, a2_after[0]}, 32'd31934);
    chk("a2_after_hi", {16'b0, a2_after[1]}, 32'h1234);
    chk("a2_one_step", 32'(a2_changes - ch0), 32'd1);

    dlf_out = 16'hA55A;
    run_frame(CMD_RD_BURST, 8'd12, 2, 8'h00, 8'h00, 8'h00, -1, 2);
    chk("snap_lo", {24'b0, rx_q[2]}, 32'h5A);
    chk("snap_hi", {24'b0, rx_q[3]}, 32'hA5);
    run_frame(CMD_RD_BURST, 8'd13, 2, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("wrap_13", {24'b0, rx_q[2]}, 32'hA5);
    chk("wrap_0",  {24'b0, rx_q[3]}, 32'h5A);

    run_frame(CMD_WR, 8'd0, 1, 8'hFF, 8'h00, 8'h00, 21, 0);
    run_frame(CMD_RD, 8'd0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("abort_keep", {24'b0, rx_q[2]}, 32'h5A);

    run_frame(8'h00, 8'd0, 1, 8'h11, 8'h00, 8'h00, -1, 0);
    run_frame(CMD_WR, 8'd20, 1, 8'h22, 8'h00, 8'h00, -1, 0);
    run_frame(CMD_RD, 8'd20, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("rd_oob", {24'b0, rx_q[2]}, 32'h00);
    run_frame(CMD_RD, 8'd0, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("bad_cmd_keep", {24'b0, rx_q[2]}, 32'h5A);

    // Reset pulsed in the middle of a burst write.
    spi_begin();
    spi_bits(CMD_WR_BURST, 8, rx);
    spi_bits(8'd2, 8, rx);
    spi_bits(8'h55, 8, rx);
    spi_bits(8'h66, 8, rx);
    chk("mid_a2", {16'b0, dlf_a2}, 32'h6655);
    spi_bits(8'h77, 3, rx);
    por_rstn = 1'b0;
    wait_clk(2);
    model_reset();
    check_outputs("in_reset");
    por_rstn = 1'b1;
    wait_clk(3);
    spi_bits(8'h88, 8, rx);
    spi_end();
    check_outputs("after_reset");
    run_frame(CMD_WR_BURST, 8'd2, 2, 8'h34, 8'h12, 8'h00, -1, 0);
    chk("post_rst_a2", {16'b0, dlf_a2}, 32'h1234);
    run_frame(CMD_RD, 8'd3, 1, 8'h00, 8'h00, 8'h00, -1, 0);
    chk("post_rst_rd", {24'b0, rx_q[2]}, 32'h12);

    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 5))
        0: cmd = CMD_RD;
        1: cmd = CMD_RD_BURST;
        2: cmd = CMD_WR;
        3: cmd = CMD_WR_BURST;
        4: cmd = 8'($urandom);
        default: cmd = ($urandom_range(0, 1) == 0) ? CMD_WR_BURST : CMD_RD_BURST;
      endcase
      addr = ($urandom_range(0, 9) == 0) ? 8'd20 : 8'($urandom_range(0, 15));
      nd   = $urandom_range(1, 3);
      cut  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8 * (2 + nd) - 1) : -1;
      run_frame(cmd, addr, nd, 8'($urandom), 8'($urandom), 8'($urandom), cut, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
